// File: rtl/mem_port_arbiter.sv
// Shared memory port sequencer: round-robin between fetch and data,
// req/ack bus handshake with a bounded wait and pipeline stall outputs.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_stall,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_valid,
  output logic              i_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              bus_err
);

  typedef enum logic [2:0] {
    IDLE, D_BUS, I_BUS, D_DONE, I_DONE
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              last_i_q, last_i_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] drd_q, drd_d;
  logic [DATA_W-1:0] ird_q, ird_d;
  logic              ddone_q, ddone_d;
  logic              ival_q, ival_d;
  logic              err_q, err_d;
  logic              d_pend;
  logic              is_d;

  assign d_pend = d_read | d_write;
  assign is_d   = (state_q == D_BUS);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_i_d = last_i_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    drd_d    = drd_q;
    ird_d    = ird_q;
    ddone_d  = 1'b0;
    ival_d   = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Data wins a tie unless it was the last one served.
        if (d_pend && (!i_req || last_i_q)) begin
          state_d = D_BUS;
          req_d   = 1'b1;
          we_d    = d_write;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          cnt_d   = '0;
        end else if (i_req) begin
          state_d = I_BUS;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = i_addr;
          wdata_d = '0;
          cnt_d   = '0;
        end
      end
      D_BUS, I_BUS: begin
        if (mem_ack) begin
          req_d = 1'b0;
          if (is_d) begin
            drd_d   = mem_rdata;
            ddone_d = 1'b1;
            state_d = D_DONE;
          end else begin
            ird_d   = mem_rdata;
            ival_d  = 1'b1;
            state_d = I_DONE;
          end
        end else if (cnt_q == CNT_LAST) begin
          req_d = 1'b0;
          err_d = 1'b1;
          if (is_d) begin
            drd_d   = '0;
            ddone_d = 1'b1;
            state_d = D_DONE;
          end else begin
            ird_d   = '0;
            ival_d  = 1'b1;
            state_d = I_DONE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      D_DONE: begin
        last_i_d = 1'b0;
        state_d  = IDLE;
      end
      I_DONE: begin
        last_i_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      last_i_q <= 1'b1;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      drd_q    <= '0;
      ird_q    <= '0;
      ddone_q  <= 1'b0;
      ival_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_i_q <= last_i_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      drd_q    <= drd_d;
      ird_q    <= ird_d;
      ddone_q  <= ddone_d;
      ival_q   <= ival_d;
      err_q    <= err_d;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign d_rdata   = drd_q;
  assign i_rdata   = ird_q;
  assign d_done    = ddone_q;
  assign i_valid   = ival_q;
  assign bus_err   = err_q;
  assign d_stall   = d_pend & ~ddone_q;
  assign i_stall   = i_req & ~ival_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: bus issue order, completion
// data, latency, round-robin, timeout and reset-abort behaviour.
module tb_mem_port_arbiter;

  localparam logic [31:0] K = 32'hA5A5_0000;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } done_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_read, d_write;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        d_done, d_stall;
  logic        i_req;
  logic [31:0] i_addr, i_rdata;
  logic        i_valid, i_stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack, bus_err;

  bus_t  bus_q[$];
  done_t d_q[$];
  done_t i_q[$];
  logic  auto_ack = 1'b0;
  logic  req_prev = 1'b0;
  int    n_checks = 0;
  int    n_errors = 0;

  mem_port_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .d_read   (d_read),
    .d_write  (d_write),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_done   (d_done),
    .d_stall  (d_stall),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rdata  (i_rdata),
    .i_valid  (i_valid),
    .i_stall  (i_stall),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .bus_err  (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Auto responder: ack in the same cycle mem_req is seen.
  always @(posedge clk) begin
    #1;
    if (auto_ack) begin
      mem_ack   = mem_req;
      mem_rdata = mem_addr ^ K;
    end
  end

  always @(negedge clk) begin
    bus_t  b;
    done_t e;
    if (mem_req && !req_prev) begin
      if (bus_q.size() == 0) begin
        check("bus_unexp", {31'b0, mem_req}, 32'd0);
      end else begin
        b = bus_q.pop_front();
        check("bus_we", {31'b0, mem_we}, {31'b0, b.we});
        check("bus_addr", mem_addr, b.addr);
        check("bus_wdata", mem_wdata, b.wdata);
      end
    end
    req_prev = mem_req;
    if (d_done) begin
      if (d_q.size() == 0) begin
        check("d_unexp", {31'b0, d_done}, 32'd0);
      end else begin
        e = d_q.pop_front();
        check("d_rdata", d_rdata, e.rdata);
        check("d_err", {31'b0, bus_err}, {31'b0, e.err});
      end
    end
    if (i_valid) begin
      if (i_q.size() == 0) begin
        check("i_unexp", {31'b0, i_valid}, 32'd0);
      end else begin
        e = i_q.pop_front();
        check("i_rdata", i_rdata, e.rdata);
        check("i_err", {31'b0, bus_err}, {31'b0, e.err});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    d_read = 0; d_write = 0; d_addr = 0; d_wdata = 0;
    i_req = 0; i_addr = 0; mem_rdata = 0; mem_ack = 0;
    tick();
    tick();
    check("rst_req", {31'b0, mem_req}, 32'd0);
    check("rst_we", {31'b0, mem_we}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_ddone", {31'b0, d_done}, 32'd0);
    check("rst_ival", {31'b0, i_valid}, 32'd0);
    check("rst_err", {31'b0, bus_err}, 32'd0);
    check("rst_drd", d_rdata, 32'd0);

    // Single load, ack in cycle 2
    rst = 1'b0;
    d_read = 1; d_addr = 32'h40; d_wdata = 0;
    bus_q.push_back('{1'b0, 32'h40, 32'h0});
    d_q.push_back('{32'hDEADBEEF, 1'b0});
    #1;
    check("ld_stall0", {31'b0, d_stall}, 32'd1);
    tick();
    check("ld_req1", {31'b0, mem_req}, 32'd1);
    check("ld_we1", {31'b0, mem_we}, 32'd0);
    check("ld_stall1", {31'b0, d_stall}, 32'd1);
    tick();
    mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    check("ld_req2", {31'b0, mem_req}, 32'd1);
    check("ld_stall2", {31'b0, d_stall}, 32'd1);
    tick();
    mem_ack = 0;
    check("ld_done3", {31'b0, d_done}, 32'd1);
    check("ld_rdata3", d_rdata, 32'hDEADBEEF);
    check("ld_stall3", {31'b0, d_stall}, 32'd0);
    check("ld_req3", {31'b0, mem_req}, 32'd0);
    tick();
    d_read = 0;
    check("ld_done4", {31'b0, d_done}, 32'd0);
    tick();

    // Store, ack in cycle 1
    d_write = 1; d_addr = 32'h80; d_wdata = 32'h12345678;
    bus_q.push_back('{1'b1, 32'h80, 32'h12345678});
    d_q.push_back('{32'h5555, 1'b0});
    tick();
    mem_ack = 1; mem_rdata = 32'h5555;
    check("st_we", {31'b0, mem_we}, 32'd1);
    check("st_wdata", mem_wdata, 32'h12345678);
    tick();
    mem_ack = 0;
    check("st_done2", {31'b0, d_done}, 32'd1);
    tick();
    d_write = 0; d_wdata = 0;
    check("st_done3", {31'b0, d_done}, 32'd0);
    tick();

    // Contention from reset: D, I, D, I
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    d_read = 1; d_addr = 32'h100;
    i_req = 1; i_addr = 32'h200;
    auto_ack = 1;
    for (int n = 0; n < 2; n++) begin
      bus_q.push_back('{1'b0, 32'h100, 32'h0});
      bus_q.push_back('{1'b0, 32'h200, 32'h0});
      d_q.push_back('{32'h100 ^ K, 1'b0});
      i_q.push_back('{32'h200 ^ K, 1'b0});
    end
    for (int c = 1; c < 12; c++) begin
      tick();
      check("ct_req", {31'b0, mem_req}, {31'b0, (c % 3) == 1});
      check("ct_dd", {31'b0, d_done}, {31'b0, (c % 6) == 2});
      check("ct_iv", {31'b0, i_valid}, {31'b0, (c % 6) == 5});
    end
    tick();
    d_read = 0; i_req = 0;
    auto_ack = 0; mem_ack = 0;
    tick();
    check("ct_idle", {31'b0, mem_req}, 32'd0);

    // Fetch timeout with TIMEOUT=4
    i_req = 1; i_addr = 32'h300;
    bus_q.push_back('{1'b0, 32'h300, 32'h0});
    i_q.push_back('{32'h0, 1'b1});
    #1;
    check("to_stall0", {31'b0, i_stall}, 32'd1);
    for (int c = 1; c <= 4; c++) begin
      tick();
      check("to_req", {31'b0, mem_req}, 32'd1);
      check("to_err_early", {31'b0, bus_err}, 32'd0);
    end
    tick();
    check("to_req5", {31'b0, mem_req}, 32'd0);
    check("to_err5", {31'b0, bus_err}, 32'd1);
    check("to_val5", {31'b0, i_valid}, 32'd1);
    check("to_rdata5", i_rdata, 32'd0);
    check("to_stall5", {31'b0, i_stall}, 32'd0);
    tick();
    i_req = 0;
    check("to_err6", {31'b0, bus_err}, 32'd0);
    check("to_val6", {31'b0, i_valid}, 32'd0);
    tick();

    // Reset during a data wait, late ack
    d_read = 1; d_addr = 32'h500;
    bus_q.push_back('{1'b0, 32'h500, 32'h0});
    tick();
    check("rm_req1", {31'b0, mem_req}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; d_read = 0;
    mem_ack = 1; mem_rdata = 32'h77;
    check("rm_req3", {31'b0, mem_req}, 32'd0);
    check("rm_done3", {31'b0, d_done}, 32'd0);
    check("rm_drd3", d_rdata, 32'd0);
    check("rm_addr3", mem_addr, 32'd0);
    check("rm_err3", {31'b0, bus_err}, 32'd0);
    tick();
    mem_ack = 0;
    check("rm_req4", {31'b0, mem_req}, 32'd0);
    check("rm_done4", {31'b0, d_done}, 32'd0);
    check("rm_drd4", d_rdata, 32'd0);
    tick();

    // Read and write together is a write
    d_read = 1; d_write = 1;
    d_addr = 32'h600; d_wdata = 32'hCAFEF00D;
    auto_ack = 1;
    bus_q.push_back('{1'b1, 32'h600, 32'hCAFEF00D});
    d_q.push_back('{32'h600 ^ K, 1'b0});
    tick();
    check("co_we", {31'b0, mem_we}, 32'd1);
    for (int i = 0; i < 10 && !d_done; i++) tick();
    check("co_done", {31'b0, d_done}, 32'd1);
    tick();
    d_read = 0; d_write = 0;
    auto_ack = 0; mem_ack = 0;
    tick();
    tick();

    check("bus_left", bus_q.size(), 32'd0);
    check("d_left", d_q.size(), 32'd0);
    check("i_left", i_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
